// File: rtl/mix_pkg.sv
// mix_pkg: shared states, sample/accumulator widths and the output saturation helper.
package mix_pkg;
  typedef enum logic [2:0] {IDLE, HDR, FETCH, SUM, OUT} state_t;
  localparam int SAMPLE_W = 16;
  localparam int ACC_W = 25;
  localparam int UNITY_GAIN = 128;
  // Clamp to the signed sample range: in range iff all bits above the sample sign bit match it.
  function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    return (a[ACC_W-1:SAMPLE_W-1] == {(ACC_W-SAMPLE_W+1){a[ACC_W-1]}}) ? a[SAMPLE_W-1:0]
      : {a[ACC_W-1], {(SAMPLE_W-1){~a[ACC_W-1]}}};
  endfunction
endpackage

// File: rtl/mix_mac.sv
// mix_mac: scales one signed audio half by an unsigned gain, accumulates it and saturates the sum.
module mix_mac
  import mix_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [7:0]          gain,
  output logic [SAMPLE_W-1:0] sat
);
  logic signed [ACC_W-1:0] acc, prod;
  always_comb prod = ACC_W'($signed(sample)) * ACC_W'($signed({1'b0, gain}));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + (prod >>> $clog2(UNITY_GAIN));
  end
  assign sat = saturate(acc);
endmodule

// File: rtl/mix_engine.sv
// mix_engine: reads per-channel sample streams from SDRAM, mixes them with gain and
// offers each saturated stereo frame to the audio sink a fixed number of times.
module mix_engine
  import mix_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 23,
  parameter int REPEAT = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH-1:0]        mix_load,
  input  logic [NUM_CH*ADDR_W-1:0] mix_select,
  input  logic [NUM_CH*8-1:0]      mix_gain,
  input  logic                     mix_stop,
  output logic                     mix_done,
  output logic [NUM_CH-1:0]        mix_active,
  output logic                     mix_read,
  output logic [ADDR_W-1:0]        mix_addr,
  input  logic [31:0]              mix_readdata,
  input  logic                     mix_sdram_finished,
  output logic                     mix_audio_valid,
  output logic [31:0]              mix_audio_data,
  input  logic                     mix_audio_ready
);
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);
  localparam logic [1:0] LAST_R = 2'(REPEAT - 1);
  state_t state, next;
  logic [ADDR_W-1:0] pend_addr [NUM_CH];
  logic [ADDR_W-1:0] addr_ch [NUM_CH];
  logic [ADDR_W-1:0] end_ch [NUM_CH];
  logic [ADDR_W-1:0] len;
  logic [NUM_CH-1:0] pending, clr_pend;
  logic [SW-1:0] slot, cur, sel;
  logic [1:0] cnt;
  logic abort, kill, fin, hs, issue, slot_done, acc_en, last_hs, more;
  logic [SAMPLE_W-1:0] sat_l, sat_r;

  // abort remembers a stop until an in-flight read has drained and IDLE is reached
  assign kill = mix_stop || abort;
  assign fin = mix_read && mix_sdram_finished;
  assign mix_audio_valid = state == OUT && !mix_stop;
  assign hs = mix_audio_valid && mix_audio_ready;
  assign last_hs = hs && cnt == LAST_R;
  assign more = |(pending | mix_load);
  assign len = mix_readdata[ADDR_W-1:0];
  assign clr_pend = (state == HDR && fin && !kill) ? NUM_CH'(1) << cur : '0;
  assign slot_done = state == FETCH && (fin || (!mix_read && !mix_active[slot]));
  assign issue = !kill && !mix_read && ((state == HDR && |pending) || (state == FETCH && mix_active[slot]));
  assign acc_en = state == FETCH && fin && !kill;

  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (pending[i]) sel = SW'(i);
  end

  always_comb begin
    next = state;
    if (kill) next = (mix_read && !mix_sdram_finished) ? state : IDLE;
    else
      case (state)
        IDLE:  next = |pending ? HDR : IDLE;
        HDR:   next = (fin && !(|((pending & ~clr_pend) | mix_load))) ? FETCH : HDR;
        FETCH: next = (slot_done && slot == LAST) ? SUM : FETCH;
        SUM:   next = OUT;
        OUT:   next = last_hs ? (more ? HDR : |mix_active ? FETCH : IDLE) : OUT;
        default: next = IDLE;
      endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mix_read <= 1'b0;
      mix_addr <= '0;
      mix_done <= 1'b0;
      mix_active <= '0;
      mix_audio_data <= '0;
      pending <= '0;
      slot <= '0;
      cur <= '0;
      cnt <= '0;
      abort <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        pend_addr[k] <= '0;
        addr_ch[k] <= '0;
        end_ch[k] <= '0;
      end
    end else begin
      abort <= mix_stop || (abort && state != IDLE);
      mix_done <= state == OUT && !kill && last_hs && !more && !(|mix_active);
      pending <= mix_stop ? '0 : (pending & ~clr_pend) | mix_load;
      for (int k = 0; k < NUM_CH; k++)
        if (mix_load[k] && !mix_stop) pend_addr[k] <= mix_select[k*ADDR_W +: ADDR_W];
      if (issue) begin
        mix_read <= 1'b1;
        mix_addr <= state == HDR ? pend_addr[sel] : addr_ch[slot] + 1'b1;
        cur <= sel;
      end else if (fin) mix_read <= 1'b0;
      slot <= state != FETCH ? '0 : slot_done ? (slot == LAST ? '0 : slot + 1'b1) : slot;
      cnt <= state == SUM ? '0 : hs ? cnt + 1'b1 : cnt;
      if (state == SUM && !kill) mix_audio_data <= {sat_l, sat_r};
      if (mix_stop) mix_active <= '0;
      else if (fin && !kill && state == HDR) begin
        addr_ch[cur] <= mix_addr;
        end_ch[cur] <= mix_addr + len;
        mix_active[cur] <= |len;
      end else if (acc_en) begin
        addr_ch[slot] <= mix_addr;
        if (mix_addr == end_ch[slot]) mix_active[slot] <= 1'b0;
      end
    end
  end

  mix_mac u_left (
    .clk(i_clk), .rst_n(i_rst_n), .clr(state == IDLE || state == SUM), .en(acc_en),
    .sample(mix_readdata[31:16]), .gain(mix_gain[slot*8 +: 8]), .sat(sat_l)
  );
  mix_mac u_right (
    .clk(i_clk), .rst_n(i_rst_n), .clr(state == IDLE || state == SUM), .en(acc_en),
    .sample(mix_readdata[15:0]), .gain(mix_gain[slot*8 +: 8]), .sat(sat_r)
  );
endmodule

// File: doc/mix_engine.md
MIX_ENGINE -- requirements
Module: mix_engine

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of mix channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 23, meaning SDRAM word-address width.
REQ-003 SHALL have parameter REPEAT, default 2, meaning number of times each mixed frame is offered to audio (1..4).
REQ-004 SHALL have port i_clk  in  1  meaning the single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port i_rst_n  in  1  meaning reset; reset is asynchronous and active-low.
REQ-006 SHALL have port mix_load  in  NUM_CH  meaning per-channel load pulse.
REQ-007 SHALL have port mix_select  in  NUM_CH*ADDR_W  meaning per-channel start address; channel k occupies bits k*ADDR_W+:ADDR_W.
REQ-008 SHALL have port mix_gain  in  NUM_CH*8  meaning per-channel unsigned gain; 128 = unity.
REQ-009 SHALL have port mix_stop  in  1  meaning abort-all pulse.
REQ-010 SHALL have port mix_done  out  1  meaning one-cycle pulse when all channels have ended.
REQ-011 SHALL have port mix_active  out  NUM_CH  meaning per-channel playing flags.
REQ-012 SHALL have ports mix_read out 1, mix_addr out ADDR_W, mix_readdata in 32, mix_sdram_finished in 1, meaning the SDRAM read port.
REQ-013 SHALL have ports mix_audio_valid out 1, mix_audio_data out 32, mix_audio_ready in 1, meaning the audio sink port.

Function
REQ-014 SHALL use sample word format {left[31:16], right[15:0]}, both signed two's complement.
REQ-015 SHALL treat the SDRAM word at the start address as length L (low ADDR_W bits); samples SHALL occupy start+1..start+L, with addresses wrapping mod 2^ADDR_W.
REQ-016 SHALL hold mix_read=1 with stable mix_addr until the cycle mix_sdram_finished=1; readdata SHALL be captured in that cycle only.
REQ-017 SHALL implement FSM IDLE, HDR, FETCH, SUM, OUT.
REQ-018 IDLE: SHALL go to HDR when any load is pending.
REQ-019 HDR: SHALL read the header of the lowest-index pending channel, set end=start+L, and set active if L!=0; SHALL repeat while pending remain, then go to FETCH.
REQ-020 FETCH: SHALL visit slots 0..NUM_CH-1 one slot per cycle (inactive) or one read (active); each read sample SHALL be scaled per half as (s*gain)>>>7 and added into 25-bit signed per-half accumulators.
REQ-021 FETCH: channel SHALL clear active when its address reaches end after the read.
REQ-022 SUM: SHALL saturate each accumulator half to [-32768, 32767] into mix_audio_data in one cycle, then go to OUT.
REQ-023 OUT: SHALL hold valid with stable data until REPEAT accepted handshakes (valid&&ready); then go to HDR if loads are pending, FETCH if any channel is active, else IDLE with mix_done pulsed.
REQ-024 A mix_load during any state SHALL latch its address into the pending set; a reload of an active channel SHALL restart it at the next HDR.
REQ-025 Simultaneous loads SHALL all be latched and then serviced in ascending index.
REQ-026 mix_stop SHALL clear all active and pending flags; an outstanding SDRAM read SHALL complete before entry to IDLE, and no frame SHALL be emitted.
REQ-027 mix_stop SHALL take priority over a same-cycle mix_load.
REQ-028 A channel with L=0 SHALL never assert active; if no other channel is active, mix_done SHALL pulse.
REQ-029 Zero active channels with a frame in OUT SHALL output 0.

Reset
REQ-030 While i_rst_n=0: state=IDLE; mix_read, mix_audio_valid, mix_done and mix_active SHALL be 0; mix_addr, mix_audio_data, accumulators, pending and end registers SHALL be 0.
REQ-031 Reset mid-transaction SHALL drop the read immediately with no recovery handshake.

Structure
REQ-032 Package mix_pkg SHALL hold the state enum, SAMPLE_W=16, ACC_W=25, UNITY_GAIN=128, and the saturate function.
REQ-033 Sub-module mix_mac SHALL perform the per-half scale-accumulate-saturate; there SHALL be one instance per half.

Verification
REQ-034 Load ch0 @0x100 with L=2, samples 0x1000_F000 and 0x0800_0800, gain 128, REPEAT=2 -> outputs 0x1000F000 ×2, 0x08000800 ×2, then mix_done.
REQ-035 Load ch0 and ch1 in the same cycle, each sample 0x7000_8000 at gain 128 -> output 0x7FFF8000 (saturated both halves); header reads occur in order ch0 then ch1.
REQ-036 Gain 64 on sample 0x0100_FF00 -> output 0x0080FF80.
REQ-037 mix_stop while mix_read is high with finished delayed 5 cycles -> read held until finished, then IDLE; no valid asserted; mix_active=0.
REQ-038 Header L=0 -> mix_active stays 0 and mix_done pulses; start address 0x7FFFFF with L=1 -> sample read from 0x000000.
